// File: rtl/ehl_gpio_pkg.sv
// rtl/ehl_gpio_pkg.sv - shared state encoding and helpers for the GPIO event queue
package ehl_gpio_pkg;

  typedef enum logic [2:0] {
    EVQ_IDLE     = 3'd0,
    EVQ_READ     = 3'd1,
    EVQ_CHECK    = 3'd2,
    EVQ_DISPATCH = 3'd3,
    EVQ_CLR      = 3'd4,
    EVQ_GUARD    = 3'd5
  } evq_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ehl_gpio_prio_enc.sv
// rtl/ehl_gpio_prio_enc.sv - lowest-set-bit priority encoder, pin 0 has highest priority
module ehl_gpio_prio_enc import ehl_gpio_pkg::*; #(
  parameter int WIDTH = 32,
  localparam int IDXW = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDXW-1:0]  o_idx,
  output logic [WIDTH-1:0] o_onehot,
  output logic             o_any,
  output logic             o_single
);

  always_comb begin
    o_idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = i[IDXW-1:0];
    end
  end

  assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
  assign o_any    = |i_vec;
  assign o_single = o_any && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/ehl_gpio_evq.sv
// rtl/ehl_gpio_evq.sv - reads GIFR on interrupt, dispatches pending pins as events, clears each flag
module ehl_gpio_evq import ehl_gpio_pkg::*; #(
  parameter int         WIDTH        = 32,
  parameter logic [0:0] IFG_POLARITY = 1'b1,
  parameter int         READ_LATENCY = 0,
  localparam int        IDXW         = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ifg,
  output logic             read_gifr,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] clr_gifr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDXW-1:0]  evt_pin,
  output logic             evt_last,
  output logic             busy,
  output logic             spurious
);

  localparam logic RL_LAST = (READ_LATENCY != 0);

  evq_state_t       r_state;
  logic [WIDTH-1:0] r_pend;
  logic             r_wait;
  logic             r_read_gifr;
  logic [WIDTH-1:0] r_clr_gifr;
  logic             r_evt_valid;
  logic [IDXW-1:0]  r_evt_pin;
  logic             r_evt_last;
  logic             r_spurious;

  logic             w_irq_act;
  logic [IDXW-1:0]  w_idx;
  logic [WIDTH-1:0] w_onehot;
  logic             w_any;
  logic             w_single;

  assign w_irq_act = ~(ifg ^ IFG_POLARITY[0]);

  ehl_gpio_prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
    .i_vec    (r_pend),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_any    (w_any),
    .o_single (w_single)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EVQ_IDLE;
      r_pend      <= '0;
      r_wait      <= 1'b0;
      r_read_gifr <= 1'b0;
      r_clr_gifr  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_pin   <= '0;
      r_evt_last  <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      case (r_state)
        EVQ_IDLE: begin
          if (enable && w_irq_act) begin
            r_state     <= EVQ_READ;
            r_read_gifr <= 1'b1;
            r_wait      <= 1'b0;
          end
        end
        EVQ_READ: begin
          if (r_wait == RL_LAST) begin
            r_pend      <= data_out;
            r_read_gifr <= 1'b0;
            r_state     <= EVQ_CHECK;
          end else begin
            r_wait <= 1'b1;
          end
        end
        EVQ_CHECK: begin
          if (!w_any) begin
            r_spurious <= 1'b1;
            r_state    <= EVQ_GUARD;
          end else begin
            r_evt_valid <= 1'b1;
            r_evt_pin   <= w_idx;
            r_evt_last  <= w_single;
            r_state     <= EVQ_DISPATCH;
          end
        end
        EVQ_DISPATCH: begin
          if (evt_ready) begin
            r_evt_valid <= 1'b0;
            r_clr_gifr  <= w_onehot;
            r_pend      <= r_pend & ~w_onehot;
            r_state     <= EVQ_CLR;
          end
        end
        EVQ_CLR: begin
          // r_pend already has the serviced bit removed here.
          r_clr_gifr <= '0;
          if (w_any) begin
            r_evt_valid <= 1'b1;
            r_evt_pin   <= w_idx;
            r_evt_last  <= w_single;
            r_state     <= EVQ_DISPATCH;
          end else begin
            r_state <= EVQ_GUARD;
          end
        end
        EVQ_GUARD: begin
          r_spurious <= 1'b0;
          r_state    <= EVQ_IDLE;
        end
        default: r_state <= EVQ_IDLE;
      endcase
    end
  end

  assign read_gifr = r_read_gifr;
  assign clr_gifr  = r_clr_gifr;
  assign evt_valid = r_evt_valid;
  assign evt_pin   = r_evt_pin;
  assign evt_last  = r_evt_last;
  assign spurious  = r_spurious;
  assign busy      = (r_state != EVQ_IDLE);

endmodule
